// File: rtl/snake_frame_renderer.sv
// snake_frame_renderer: rasterizes a packed snake body into a double-buffered 16x16 bitmap for a row-scanned LED matrix.
// Optional food pixel overlay on the matrix output when SNAKE_FOOD_OVERLAY_EN is defined.
module snake_frame_renderer #(
    parameter int SEGS      = 225,
    parameter int ROW_DWELL = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic [8*SEGS-1:0] snake_in,
    input  logic [3:0]        food_x,
    input  logic [3:0]        food_y,
    input  logic              food_en,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        seg_count,
    output logic              self_hit,
    output logic [15:0]       row_sel,
    output logic [15:0]       col_data
);
    localparam int DW = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;

    typedef enum logic [1:0] {IDLE, CLEAR, SCAN, SWAP} state_t;

    state_t            state;
    logic [8*SEGS-1:0] snap;
    logic [15:0]       back  [16];
    logic [15:0]       front [16];
    logic [7:0]        idx;
    logic [7:0]        cnt;
    logic              hit;
    logic [7:0]        cur;
    logic [DW-1:0]     dwell;
    logic [3:0]        row;
    logic [3:0]        nr;
    logic              wrap;
    logic [15:0]       food;

    // The snapshot shifts down one byte per scanned slot, so the current slot is always the low byte.
    assign cur = snap[7:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            seg_count  <= '0;
            self_hit   <= 1'b0;
            snap       <= '0;
            idx        <= '0;
            cnt        <= '0;
            hit        <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                back[i]  <= '0;
                front[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    if (frame_start) begin
                        snap  <= snake_in;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    back[idx[3:0]] <= '0;
                    cnt            <= '0;
                    hit            <= 1'b0;
                    idx            <= (idx == 8'd15) ? 8'd0 : idx + 8'd1;
                    state          <= (idx == 8'd15) ? SCAN : CLEAR;
                end
                SCAN: begin
                    if (cur == 8'h00) begin
                        frame_done <= 1'b1;
                        state      <= SWAP;
                    end else begin
                        back[cur[7:4]][cur[3:0]] <= 1'b1;
                        hit  <= hit | back[cur[7:4]][cur[3:0]];
                        cnt  <= cnt + 8'd1;
                        snap <= snap >> 8;
                        idx  <= idx + 8'd1;
                        if (idx == 8'(SEGS - 1)) begin
                            frame_done <= 1'b1;
                            state      <= SWAP;
                        end
                    end
                end
                default: begin
                    for (int i = 0; i < 16; i++) front[i] <= back[i];
                    seg_count  <= cnt;
                    self_hit   <= hit;
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

`ifdef SNAKE_FOOD_OVERLAY_EN
    assign food = (food_en && food_y == nr) ? 16'(1) << food_x : '0;
`else
    logic unused_food;
    assign unused_food = ^{food_en, food_x, food_y};
    assign food = '0;
`endif

    // col_data is fetched for the row being selected next, keeping it aligned with row_sel.
    assign wrap = dwell == DW'(ROW_DWELL - 1);
    assign nr   = wrap ? row + 4'd1 : row;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dwell    <= '0;
            row      <= '0;
            row_sel  <= 16'h0001;
            col_data <= '0;
        end else begin
            dwell    <= wrap ? '0 : dwell + DW'(1);
            row      <= nr;
            row_sel  <= wrap ? {row_sel[14:0], row_sel[15]} : row_sel;
            col_data <= front[nr] | food;
        end
    end
endmodule

// File: doc/snake_frame_renderer.md
# snake_frame_renderer

Downstream consumer of the snake game-state stage: snapshots the packed 1800-bit snake body vector (225 segments × 8 bits, `{y[3:0], x[3:0]}`, segment 0 at bits [7:0]), rasterizes it into a 16×16 back bitmap and swaps it into a front bitmap. The front bitmap drives a row-scanned LED matrix. Self-overlap is flagged during rasterization so game control can detect self-collision.

## Interface
- `SEGS`, 225: segment slots in `snake_in`; slot k is `snake_in[8k+7:8k]`.
- `ROW_DWELL`, 1024: clk cycles each matrix row stays selected (≥2).
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset; one clock, asynchronous and active-low.
- `frame_start`  in  1  single-cycle request to render a new frame; honoured only in IDLE.
- `snake_in`  in  8*SEGS  packed snake body; byte 8'h00 marks end of body.
- `food_x`, `food_y`  in  4 each  food cell.
- `food_en`  in  1  food pixel present.
- `busy`  out  1  high in CLEAR/SCAN/SWAP.
- `frame_done`  out  1  one-cycle pulse in SWAP.
- `seg_count`  out  8  valid segments in last completed frame.
- `self_hit`  out  1  last completed frame had ≥2 segments on one cell.
- `row_sel`  out  16  one-hot active-high row select.
- `col_data`  out  16  pixel data for selected row; bit x = column x.

## Operation
- FSM states: IDLE, CLEAR, SCAN, SWAP.
- IDLE + `frame_start`=1: capture `snake_in` into an internal snapshot, go to CLEAR. `frame_start` in any other state is ignored (not queued).
- CLEAR: 16 cycles, zero back-buffer row r on cycle r. Clear the running hit flag and the counter.
- SCAN: one slot per cycle, k = 0,1,…
  - If byte k = 8'h00, end the scan. The byte does not plot and is not counted.
  - Otherwise set `back[y][x]` and increment the counter. If that bit was already 1 (including a write earlier in this frame), set the running hit flag.
  - Slots after the first zero byte are never examined.
  - After slot SEGS-1 is processed, go to SWAP even if no zero byte was found.
- SWAP: copy back buffer to front buffer, load `seg_count` and `self_hit` from the running values, pulse `frame_done`, return to IDLE.
- Cell (0,0) is not drawable, because byte 0 is the terminator.
- Row scanner runs independently of the FSM:
  - A dwell counter counts 0…ROW_DWELL-1.
  - On wrap, `row_sel` rotates left: 0x0001→0x0002→…→0x8000→0x0001.
  - `col_data` is registered from `front[row]`, aligned with `row_sel`.
  - A front-buffer update shows on the next `col_data` register cycle, with no tearing wait.

## Timing
- Reset values (asserted asynchronously):
  - FSM = IDLE.
  - `busy`=0, `frame_done`=0, `seg_count`=0, `self_hit`=0.
  - `row_sel`=16'h0001, `col_data`=0.
  - Both bitmaps zero, dwell counter 0.
- Reset mid-frame aborts the frame with no `frame_done`; the next frame needs a new `frame_start`.
- Latency: `frame_start` sampled at edge E; let L = number of nonzero bytes before the first zero byte.
  - `busy` is high from E+1.
  - `frame_done` and SWAP occur in cycle E+17+min(L+1, SEGS).
  - `busy` is low from the following cycle.
  - New front data appears in `col_data` on the following cycle.
- `snake_in` may change freely after E; only the snapshot is used.

## Configuration
- `SNAKE_FOOD_OVERLAY_EN` defined: `col_data` = `front[row]` OR (`food_en` && `food_y`==row ? 1<<`food_x` : 0). Food inputs are sampled every cycle and never affect `self_hit` or `seg_count`.
- Not defined: food inputs are ignored; `col_data` = `front[row]` only.

## Test plan
- Reset check: assert `reset_n`=0 mid-scan → immediately `busy`=0, `row_sel`=0x0001, `col_data`=0, `seg_count`=0, `self_hit`=0.
- Initial body: bytes 0x11,0x12,0x13 then zeros; `frame_start` at E → `frame_done` at E+21, `seg_count`=3, `self_hit`=0, row 1 `col_data`=16'h000E, all other rows 0.
- Self-hit: bytes 0x22,0x23,0x22 → `seg_count`=3, `self_hit`=1, row 2 = 16'h000C. A next frame with 0x22,0x23 → `self_hit`=0.
- Full body: all 225 bytes nonzero (0x51 repeated) → `frame_done` at E+242, `seg_count`=225, `self_hit`=1, row 5 = 16'h0002.
- Ignore and snapshot: `frame_start` pulsed again at E+5 and `snake_in` changed at E+1 → exactly one `frame_done`, image matches the E snapshot.
- Overlay (macro defined): food (x=7, y=1), `food_en`=1, initial body → row 1 = 16'h008E. Macro undefined → 16'h000E.
